// File: rtl/execute_unit_param_if.sv
// Handshake and datapath bundle between ID/RR, the execute stage and MEM.
interface execute_unit_param_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MASK_W = 8
);
  // Upstream side
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        opcode;
  logic [WIDTH-1:0]  op1_in;
  logic [WIDTH-1:0]  op2_in;
  logic [WIDTH-1:0]  imm_se;
  logic [1:0]        fwd_sel_op1;
  logic [1:0]        fwd_sel_op2;
  logic [1:0]        fwd_sel_d2;
  logic [WIDTH-1:0]  fwd_mem;
  logic [WIDTH-1:0]  fwd_wb;
  logic [WIDTH-1:0]  pc_plus1;
  logic [WIDTH-1:0]  pc_plus_imm;
  logic [2:0]        rd_in;
  logic              reg_write_in;
  logic [MASK_W-1:0] lmsm_mask;
  // Downstream side
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  alu_out;
  logic [WIDTH-1:0]  store_data;
  logic [2:0]        rd_out;
  logic              reg_write_out;
  logic              mem_read;
  logic              mem_write;
  logic              branch_taken;
  logic [WIDTH-1:0]  branch_target;
  logic              carry_flag;
  logic              zero_flag;
  logic              busy;

  modport master (
    output in_valid, opcode, op1_in, op2_in, imm_se, fwd_sel_op1, fwd_sel_op2, fwd_sel_d2,
           fwd_mem, fwd_wb, pc_plus1, pc_plus_imm, rd_in, reg_write_in, lmsm_mask, out_ready,
    input  in_ready, out_valid, alu_out, store_data, rd_out, reg_write_out, mem_read,
           mem_write, branch_taken, branch_target, carry_flag, zero_flag, busy
  );

  modport slave (
    input  in_valid, opcode, op1_in, op2_in, imm_se, fwd_sel_op1, fwd_sel_op2, fwd_sel_d2,
           fwd_mem, fwd_wb, pc_plus1, pc_plus_imm, rd_in, reg_write_in, lmsm_mask, out_ready,
    output in_ready, out_valid, alu_out, store_data, rd_out, reg_write_out, mem_read,
           mem_write, branch_taken, branch_target, carry_flag, zero_flag, busy
  );
endinterface

// File: rtl/execute_unit_param.sv
// Execute stage: forwarding muxes, ALU, C/Z flags, branch resolution, LM/SM beat sequencer,
// and a registered EX/MEM output slot with valid/ready flow control.
module execute_unit_param #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MASK_W = 8
) (
  input logic                clk,
  input logic                rst,
  execute_unit_param_if.slave bus
);
  localparam int unsigned IDX_W = (MASK_W > 1) ? $clog2(MASK_W) : 1;
  localparam int unsigned CNT_W = IDX_W + 1;

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpAdi = 4'b0001;
  localparam logic [3:0] OpNdu = 4'b0010;
  localparam logic [3:0] OpLhi = 4'b0011;
  localparam logic [3:0] OpLw  = 4'b0100;
  localparam logic [3:0] OpSw  = 4'b0101;
  localparam logic [3:0] OpLm  = 4'b0110;
  localparam logic [3:0] OpSm  = 4'b0111;
  localparam logic [3:0] OpJal = 4'b1000;
  localparam logic [3:0] OpJlr = 4'b1001;
  localparam logic [3:0] OpBeq = 4'b1100;

  typedef enum logic [0:0] {StIdle, StMulti} state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  alu_out_q, alu_out_d;
  logic [WIDTH-1:0]  store_data_q, store_data_d;
  logic [2:0]        rd_out_q, rd_out_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              branch_taken_q, branch_taken_d;
  logic [WIDTH-1:0]  branch_target_q, branch_target_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic [WIDTH-1:0]  base_q, base_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_lm_q, is_lm_d;

  logic              load;
  logic [3:0]        op;
  logic [1:0]        cz;
  logic [WIDTH-1:0]  opa, opb, opd;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  addr, nand_r;
  logic              cond_ok;
  logic [IDX_W-1:0]  low_idx;
  logic [MASK_W-1:0] mask_rest;

  // The output slot can take a new beat when empty or being drained this cycle.
  assign load         = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = load & (state_q == StIdle);

  assign op        = bus.opcode[5:2];
  assign cz        = bus.opcode[1:0];
  assign sum       = {1'b0, opa} + {1'b0, opb};
  assign addr      = opa + bus.imm_se;
  assign nand_r    = ~(opa & opb);
  assign mask_rest = mask_q & (mask_q - MASK_W'(1));

  // Forwarding muxes for operand A, operand B and store data.
  always_comb begin
    opa = bus.op1_in;
    opb = bus.op2_in;
    opd = bus.op2_in;
    case (bus.fwd_sel_op1)
      2'd1:    opa = bus.fwd_mem;
      2'd2:    opa = bus.fwd_wb;
      2'd3:    opa = '0;
      default: ;
    endcase
    case (bus.fwd_sel_op2)
      2'd1:    opb = bus.fwd_mem;
      2'd2:    opb = bus.fwd_wb;
      2'd3:    opb = bus.imm_se;
      default: ;
    endcase
    case (bus.fwd_sel_d2)
      2'd1:    opd = bus.fwd_mem;
      2'd2:    opd = bus.fwd_wb;
      2'd3:    opd = '0;
      default: ;
    endcase
  end

  // Conditional ADD/NDU qualifier; CZ=11 behaves like CZ=00.
  always_comb begin
    cond_ok = 1'b1;
    case (cz)
      2'b10:   cond_ok = carry_q;
      2'b01:   cond_ok = zero_q;
      default: ;
    endcase
  end

  // Lowest remaining mask bit is the register index of the next LM/SM beat.
  always_comb begin
    low_idx = '0;
    for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = IDX_W'(i);
    end
  end

  // Next-state: output slot contents, flags and the LM/SM sequencer.
  always_comb begin
    state_d         = state_q;
    out_valid_d     = out_valid_q;
    alu_out_d       = alu_out_q;
    store_data_d    = store_data_q;
    rd_out_d        = rd_out_q;
    reg_write_d     = reg_write_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    branch_taken_d  = branch_taken_q;
    branch_target_d = branch_target_q;
    carry_d         = carry_q;
    zero_d          = zero_q;
    base_d          = base_q;
    mask_d          = mask_q;
    cnt_d           = cnt_q;
    is_lm_d         = is_lm_q;
    if (load) begin
      // Every loaded beat starts from a clean slate so stale control never leaks.
      out_valid_d     = 1'b0;
      alu_out_d       = '0;
      store_data_d    = '0;
      rd_out_d        = '0;
      reg_write_d     = 1'b0;
      mem_read_d      = 1'b0;
      mem_write_d     = 1'b0;
      branch_taken_d  = 1'b0;
      branch_target_d = '0;
      if (state_q == StMulti) begin
        out_valid_d = 1'b1;
        alu_out_d   = base_q + WIDTH'(cnt_q);
        rd_out_d    = 3'(low_idx);
        mem_read_d  = is_lm_q;
        reg_write_d = is_lm_q;
        mem_write_d = ~is_lm_q;
        mask_d      = mask_rest;
        cnt_d       = cnt_q + CNT_W'(1);
        if (mask_rest == '0) state_d = StIdle;
      end else if (bus.in_valid) begin
        out_valid_d = 1'b1;
        rd_out_d    = bus.rd_in;
        case (op)
          OpAdd, OpAdi: begin
            alu_out_d = sum[WIDTH-1:0];
            if (op == OpAdi || cond_ok) begin
              reg_write_d = bus.reg_write_in;
              carry_d     = sum[WIDTH];
              zero_d      = (sum[WIDTH-1:0] == '0);
            end
          end
          OpNdu: begin
            alu_out_d = nand_r;
            if (cond_ok) begin
              reg_write_d = bus.reg_write_in;
              zero_d      = (nand_r == '0);
            end
          end
          OpLhi: begin
            alu_out_d   = {bus.imm_se[8:0], {(WIDTH - 9){1'b0}}};
            reg_write_d = bus.reg_write_in;
          end
          OpLw: begin
            alu_out_d   = addr;
            mem_read_d  = 1'b1;
            reg_write_d = bus.reg_write_in;
          end
          OpSw: begin
            alu_out_d    = addr;
            mem_write_d  = 1'b1;
            store_data_d = opd;
          end
          OpLm, OpSm: begin
            // The accept itself emits nothing; beats follow from StMulti.
            out_valid_d = 1'b0;
            if (bus.lmsm_mask != '0) begin
              base_d  = opa;
              mask_d  = bus.lmsm_mask;
              cnt_d   = '0;
              is_lm_d = (op == OpLm);
              state_d = StMulti;
            end
          end
          OpJal, OpJlr: begin
            alu_out_d       = bus.pc_plus1;
            branch_taken_d  = 1'b1;
            branch_target_d = (op == OpJal) ? bus.pc_plus_imm : opb;
            reg_write_d     = bus.reg_write_in;
          end
          OpBeq: begin
            branch_taken_d  = (opa == opb);
            branch_target_d = bus.pc_plus_imm;
          end
          default: ;
        endcase
      end
    end
  end

  // State and output registers; reset abandons any LM/SM in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      out_valid_q     <= 1'b0;
      alu_out_q       <= '0;
      store_data_q    <= '0;
      rd_out_q        <= '0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
      carry_q         <= 1'b0;
      zero_q          <= 1'b0;
      base_q          <= '0;
      mask_q          <= '0;
      cnt_q           <= '0;
      is_lm_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      out_valid_q     <= out_valid_d;
      alu_out_q       <= alu_out_d;
      store_data_q    <= store_data_d;
      rd_out_q        <= rd_out_d;
      reg_write_q     <= reg_write_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
      carry_q         <= carry_d;
      zero_q          <= zero_d;
      base_q          <= base_d;
      mask_q          <= mask_d;
      cnt_q           <= cnt_d;
      is_lm_q         <= is_lm_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.alu_out       = alu_out_q;
  assign bus.store_data    = store_data_q;
  assign bus.rd_out        = rd_out_q;
  assign bus.reg_write_out = reg_write_q;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.branch_taken  = branch_taken_q;
  assign bus.branch_target = branch_target_q;
  assign bus.carry_flag    = carry_q;
  assign bus.zero_flag     = zero_q;
  assign bus.busy          = (state_q == StMulti);
endmodule

// File: tb/tb_execute_unit_param.sv
// Bench for execute_unit_param: directed vector table, LM/SM sequences (stall, wrap, reset),
// then randomized traffic scored against a queue-based reference model.
module tb_execute_unit_param;
  localparam int W = 16;
  localparam int M = 8;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] sd;
    logic [15:0] tgt;
    logic [2:0]  rd;
    logic        rw, mr, mw, bt, c, z;
  } beat_t;

  typedef struct {
    logic [5:0]  opc;
    logic [15:0] a, b, imm, fm, fw, pc1, pci;
    logic [1:0]  s1, s2, sd;
    beat_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mc, mz;
  beat_t exp_q[$];
  vec_t  vecs[19];

  always #5 clk = ~clk;

  execute_unit_param_if #(.WIDTH(W), .MASK_W(M)) bus ();
  execute_unit_param #(.WIDTH(W), .MASK_W(M)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t dut_beat();
    beat_t b;
    b.alu = bus.alu_out;      b.sd = bus.store_data;  b.tgt = bus.branch_target;
    b.rd  = bus.rd_out;       b.rw = bus.reg_write_out;
    b.mr  = bus.mem_read;     b.mw = bus.mem_write;   b.bt = bus.branch_taken;
    b.c   = bus.carry_flag;   b.z  = bus.zero_flag;
    return b;
  endfunction

  function automatic vec_t mk(input logic [5:0] opc, input logic [15:0] a, b, imm,
                              input logic [1:0] s1, s2, sd, input logic [15:0] fm, fw, pc1, pci,
                              input logic [15:0] e_alu, e_sd, e_tgt, input logic [5:0] fl);
    vec_t v;
    v.opc = opc; v.a = a; v.b = b; v.imm = imm; v.s1 = s1; v.s2 = s2; v.sd = sd;
    v.fm = fm; v.fw = fw; v.pc1 = pc1; v.pci = pci;
    v.e = '0;
    v.e.alu = e_alu; v.e.sd = e_sd; v.e.tgt = e_tgt; v.e.rd = 3'd5;
    {v.e.rw, v.e.mr, v.e.mw, v.e.bt, v.e.c, v.e.z} = fl;
    return v;
  endfunction

  task automatic set_defaults();
    bus.in_valid = 1'b0; bus.opcode = '0; bus.op1_in = '0; bus.op2_in = '0; bus.imm_se = '0;
    bus.fwd_sel_op1 = '0; bus.fwd_sel_op2 = '0; bus.fwd_sel_d2 = '0; bus.fwd_mem = '0;
    bus.fwd_wb = '0; bus.pc_plus1 = '0; bus.pc_plus_imm = '0; bus.rd_in = '0;
    bus.reg_write_in = 1'b0; bus.lmsm_mask = '0; bus.out_ready = 1'b1;
  endtask

  // Present one instruction until accepted; returns 1 time unit after the accept edge.
  task automatic send();
    int t = 0;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (t == 20) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_multi(input logic [5:0] opc, input logic [15:0] base, input logic [7:0] mask,
                           input int stall_k, input int stall_n);
    int idxs[$];
    int k = 0;
    int t = 0;
    logic lm;
    logic [63:0] exp;
    lm = (opc[5:2] == 4'b0110);
    for (int i = 0; i < 8; i++) if (mask[i]) idxs.push_back(i);
    bus.opcode = opc; bus.op1_in = base; bus.fwd_sel_op1 = 2'd0;
    bus.lmsm_mask = mask; bus.reg_write_in = 1'b1;
    send();
    check("multi_accept", {bus.busy, bus.out_valid}, {mask != 8'd0, 1'b0});
    while (k < idxs.size() && t < 40) begin
      if (bus.out_valid) begin
        exp = {16'(32'(base) + k), 3'(idxs[k]), lm, ~lm, lm, k != idxs.size() - 1};
        check($sformatf("multi_beat%0d", k),
              {bus.alu_out, bus.rd_out, bus.mem_read, bus.mem_write, bus.reg_write_out, bus.busy},
              exp);
        if (k == stall_k) begin
          bus.out_ready = 1'b0;
          repeat (stall_n) begin
            @(posedge clk); #1;
            check("multi_hold", {bus.out_valid, bus.alu_out, bus.rd_out}, {1'b1, exp[22:4]});
          end
          bus.out_ready = 1'b1;
        end
        k++;
      end
      @(posedge clk); #1; t++;
    end
    if (k < idxs.size()) begin
      n_tests++; n_fail++;
      $display("FAIL multi_timeout: got %0d beats expected %0d", k, idxs.size());
    end
    check("multi_done_ready", {bus.in_ready, bus.busy}, 2'b10);
  endtask

  function automatic logic [15:0] pick(input logic [1:0] s, input logic [15:0] r, alt);
    return (s == 2'd0) ? r : (s == 2'd1) ? bus.fwd_mem : (s == 2'd2) ? bus.fwd_wb : alt;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Reference model: what MEM should eventually see for one accepted instruction.
  task automatic model_accept();
    logic [3:0] op;
    logic [15:0] a, b, d;
    logic ok;
    int s;
    int k;
    beat_t e;
    op = bus.opcode[5:2];
    a = pick(bus.fwd_sel_op1, bus.op1_in, 16'h0000);
    b = pick(bus.fwd_sel_op2, bus.op2_in, bus.imm_se);
    d = pick(bus.fwd_sel_d2, bus.op2_in, 16'h0000);
    ok = (bus.opcode[1:0] == 2'b10) ? mc : (bus.opcode[1:0] == 2'b01) ? mz : 1'b1;
    e = '0;
    e.rd = bus.rd_in;
    case (op)
      4'd0, 4'd1: begin
        s = int'(a) + int'(b);
        e.alu = 16'(s);
        if (op == 4'd1 || ok) begin
          e.rw = bus.reg_write_in; mc = (s > 65535); mz = ((s % 65536) == 0);
        end
      end
      4'd2: begin
        e.alu = ~(a & b);
        if (ok) begin e.rw = bus.reg_write_in; mz = (e.alu == 16'd0); end
      end
      4'd3: begin e.alu = 16'(int'(bus.imm_se[8:0]) * 128); e.rw = bus.reg_write_in; end
      4'd4: begin e.alu = 16'(int'(a) + int'(bus.imm_se)); e.mr = 1'b1; e.rw = bus.reg_write_in; end
      4'd5: begin e.alu = 16'(int'(a) + int'(bus.imm_se)); e.mw = 1'b1; e.sd = d; end
      4'd6, 4'd7: begin
        k = 0;
        for (int i = 0; i < 8; i++) begin
          if (bus.lmsm_mask[i]) begin
            e = '0;
            e.alu = 16'(int'(a) + k); e.rd = 3'(i);
            e.mr = (op == 4'd6); e.rw = (op == 4'd6); e.mw = (op == 4'd7);
            e.c = mc; e.z = mz;
            exp_q.push_back(e);
            k++;
          end
        end
        return;
      end
      4'd8:  begin e.alu = bus.pc_plus1; e.bt = 1'b1; e.tgt = bus.pc_plus_imm; e.rw = bus.reg_write_in; end
      4'd9:  begin e.alu = bus.pc_plus1; e.bt = 1'b1; e.tgt = b; e.rw = bus.reg_write_in; end
      4'd12: begin e.bt = (a == b); e.tgt = bus.pc_plus_imm; end
      default: ;
    endcase
    e.c = mc; e.z = mz;
    exp_q.push_back(e);
  endtask

  task automatic score();
    beat_t e;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL rand_unexpected: got beat %h expected none", dut_beat());
    end else begin
      e = exp_q.pop_front();
      check("rand_beat", dut_beat(), e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation got no finish expected completion");
    $fatal(1);
  end

  initial begin
    //              opc        a        b        imm      s1 s2 sd fm       fw       pc1      pci       alu      sd       tgt      rw mr mw bt c z
    vecs[0]  = mk(6'b000000, 16'hFFFF, 16'h0001, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0,  16'h0,   16'h0000, 16'h0,  16'h0,   6'b100011);
    vecs[1]  = mk(6'b000010, 16'h0003, 16'h0004, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0,  16'h0,   16'h0007, 16'h0,  16'h0,   6'b100000);
    vecs[2]  = mk(6'b000010, 16'h0001, 16'h0001, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0,  16'h0,   16'h0002, 16'h0,  16'h0,   6'b000000);
    vecs[3]  = mk(6'b000001, 16'h0005, 16'h0006, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0,  16'h0,   16'h000B, 16'h0,  16'h0,   6'b000000);
    vecs[4]  = mk(6'b001000, 16'hFFFF, 16'hFFFF, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0,  16'h0,   16'h0000, 16'h0,  16'h0,   6'b100001);
    vecs[5]  = mk(6'b000001, 16'h0002, 16'h0003, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0,  16'h0,   16'h0005, 16'h0,  16'h0,   6'b100000);
    vecs[6]  = mk(6'b000100, 16'h0001, 16'h7777, 16'h2,  0, 3, 0, 16'h0,  16'h0,  16'h0,  16'h0,   16'h0003, 16'h0,  16'h0,   6'b100000);
    vecs[7]  = mk(6'b001010, 16'hF0F0, 16'h0FF0, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0,  16'h0,   16'hFF0F, 16'h0,  16'h0,   6'b000000);
    vecs[8]  = mk(6'b001100, 16'h0,    16'h0,    16'h01AB, 0, 0, 0, 16'h0, 16'h0,  16'h0,  16'h0,   16'hD580, 16'h0,  16'h0,   6'b100000);
    vecs[9]  = mk(6'b010000, 16'h1000, 16'h0,    16'hFFFF, 0, 0, 0, 16'h0, 16'h0,  16'h0,  16'h0,   16'h0FFF, 16'h0,  16'h0,   6'b110000);
    vecs[10] = mk(6'b010100, 16'h2000, 16'h1111, 16'h4,  0, 0, 1, 16'hBEEF, 16'h0, 16'h0,  16'h0,   16'h2004, 16'hBEEF, 16'h0, 6'b001000);
    vecs[11] = mk(6'b110000, 16'h9999, 16'h0005, 16'h0,  1, 0, 0, 16'h5,  16'h0,  16'h0,  16'h0040, 16'h0000, 16'h0,  16'h0040, 6'b000100);
    vecs[12] = mk(6'b110000, 16'h0005, 16'h0006, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0,  16'h0040, 16'h0000, 16'h0,  16'h0040, 6'b000000);
    vecs[13] = mk(6'b100000, 16'h0,    16'h0,    16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0011, 16'h0080, 16'h0011, 16'h0, 16'h0080, 6'b100100);
    vecs[14] = mk(6'b100100, 16'h0,    16'h1234, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0021, 16'h0999, 16'h0021, 16'h0, 16'h1234, 6'b100100);
    vecs[15] = mk(6'b101000, 16'h0001, 16'h0002, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0,  16'h0,   16'h0000, 16'h0,  16'h0,   6'b000000);
    vecs[16] = mk(6'b000000, 16'h0,    16'h8000, 16'h0,  2, 0, 0, 16'h0,  16'h8000, 16'h0, 16'h0,   16'h0000, 16'h0,  16'h0,   6'b100011);
    vecs[17] = mk(6'b111111, 16'h0001, 16'h0001, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0,  16'h0,   16'h0000, 16'h0,  16'h0,   6'b000011);
    vecs[18] = mk(6'b000011, 16'h0001, 16'h0002, 16'h0,  0, 0, 0, 16'h0,  16'h0,  16'h0,  16'h0,   16'h0003, 16'h0,  16'h0,   6'b100000);

    rst = 1'b1;
    set_defaults();
    repeat (2) @(negedge clk);
    check("reset_state", {dut_beat(), bus.out_valid, bus.busy}, 64'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", bus.in_ready, 1);

    // Directed vectors; flags carry from row to row.
    for (int i = 0; i < 19; i++) begin
      bus.opcode = vecs[i].opc; bus.op1_in = vecs[i].a; bus.op2_in = vecs[i].b;
      bus.imm_se = vecs[i].imm; bus.fwd_sel_op1 = vecs[i].s1; bus.fwd_sel_op2 = vecs[i].s2;
      bus.fwd_sel_d2 = vecs[i].sd; bus.fwd_mem = vecs[i].fm; bus.fwd_wb = vecs[i].fw;
      bus.pc_plus1 = vecs[i].pc1; bus.pc_plus_imm = vecs[i].pci; bus.rd_in = 3'd5;
      bus.reg_write_in = 1'b1; bus.lmsm_mask = '0;
      send();
      check($sformatf("vec%0d", i), {dut_beat(), bus.out_valid, bus.in_ready}, {vecs[i].e, 2'b11});
    end

    // LM/SM sequences: plain, stalled on beat 2, zero mask, SM with address wrap.
    set_defaults();
    run_multi(6'b011000, 16'h0100, 8'b1010_0101, -1, 0);
    run_multi(6'b011000, 16'h0100, 8'b1010_0101, 2, 3);
    run_multi(6'b011000, 16'h0100, 8'h00, -1, 0);
    run_multi(6'b011100, 16'hFFFF, 8'h81, -1, 0);

    // Reset in the middle of an LM, after setting C and Z.
    set_defaults();
    bus.opcode = 6'b000000; bus.op1_in = 16'hFFFF; bus.op2_in = 16'h0001; bus.reg_write_in = 1'b1;
    send();
    check("pre_reset_flags", {bus.carry_flag, bus.zero_flag}, 2'b11);
    bus.opcode = 6'b011000; bus.op1_in = 16'h0100; bus.lmsm_mask = 8'b1010_0101;
    send();
    begin
      int k = 0;
      int t = 0;
      while (k < 3 && t < 40) begin
        @(posedge clk); #1; t++;
        if (bus.out_valid) k++;
      end
      check("mid_lm_beat2", {bus.alu_out, bus.rd_out}, {16'h0102, 3'd5});
    end
    rst = 1'b1;
    #1;
    check("async_reset", {dut_beat(), bus.out_valid, bus.busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    set_defaults();
    bus.opcode = 6'b000100; bus.op1_in = 16'h0001; bus.imm_se = 16'h0002;
    bus.fwd_sel_op2 = 2'd3; bus.reg_write_in = 1'b1;
    send();
    check("post_reset_adi", {bus.out_valid, bus.alu_out, bus.busy}, {1'b1, 16'h0003, 1'b0});

    // Randomized traffic with random backpressure.
    @(negedge clk);
    rst = 1'b1;
    set_defaults();
    @(negedge clk);
    rst = 1'b0;
    mc = 1'b0; mz = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.opcode = 6'($urandom_range(0, 63));
      bus.op1_in = rnd16();
      bus.op2_in = ($urandom_range(0, 3) == 0) ? bus.op1_in : rnd16();
      bus.imm_se = rnd16();
      bus.fwd_sel_op1 = 2'($urandom_range(0, 3));
      bus.fwd_sel_op2 = 2'($urandom_range(0, 3));
      bus.fwd_sel_d2 = 2'($urandom_range(0, 3));
      bus.fwd_mem = rnd16(); bus.fwd_wb = rnd16();
      bus.pc_plus1 = 16'($urandom); bus.pc_plus_imm = 16'($urandom);
      bus.rd_in = 3'($urandom_range(0, 7));
      bus.reg_write_in = 1'($urandom_range(0, 1));
      bus.lmsm_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      #1;
      if (bus.out_valid && bus.out_ready) score();
      if (bus.in_valid && bus.in_ready) model_accept();
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (60) begin
      #1;
      if (bus.out_valid) score();
      @(negedge clk);
    end
    check("rand_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
